// File: rtl/oven_cycle_sequencer.sv
// Cook-cycle sequencer: preheat until in band, timed countdown, done hold, then idle.
// Optional door interlock is enabled by defining DOOR_INTERLOCK_EN.
module oven_cycle_sequencer #(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned INTERVAL    = 10,
  parameter int unsigned DONE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       door_open,
  input  logic [7:0] current_temp,
  input  logic [7:0] set_temp,
  input  logic [3:0] set_time,
  output logic [3:0] current_time,
  output logic       oven_start,
  output logic       oven_stop,
  output logic [1:0] phase,
  output logic       done_led
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREHEAT,
    S_COOK,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t          state, state_n;
  logic            start_q;
  logic [PW-1:0]   presc, presc_n;
  logic [DW-1:0]   done_cnt, done_cnt_n;
  logic [3:0]      time_n;
  logic            oven_start_n, oven_stop_n, done_led_n;
  logic [1:0]      phase_n;
  logic            start_edge;
  logic            start_ok;
  logic [8:0]      band_sum;
  logic            in_band;

`ifdef DOOR_INTERLOCK_EN
  state_t          resume_state, resume_state_n;
  logic            door_hold, door_hold_n;
`else
  logic            unused_door;
  assign unused_door = door_open;
`endif

  assign start_edge = start & ~start_q;
  // Widened to 9 bits so set_temp below INTERVAL always counts as in band.
  assign band_sum   = {1'b0, current_temp} + 9'(INTERVAL);
  assign in_band    = band_sum >= {1'b0, set_temp};

`ifdef DOOR_INTERLOCK_EN
  assign start_ok = start_edge & (set_time != '0) & ~door_open;
`else
  assign start_ok = start_edge & (set_time != '0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      start_q      <= 1'b0;
      presc        <= '0;
      done_cnt     <= '0;
      current_time <= '0;
      oven_start   <= 1'b0;
      oven_stop    <= 1'b1;
      phase        <= 2'd0;
      done_led     <= 1'b0;
`ifdef DOOR_INTERLOCK_EN
      resume_state <= S_COOK;
      door_hold    <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      start_q      <= start;
      presc        <= presc_n;
      done_cnt     <= done_cnt_n;
      current_time <= time_n;
      oven_start   <= oven_start_n;
      oven_stop    <= oven_stop_n;
      phase        <= phase_n;
      done_led     <= done_led_n;
`ifdef DOOR_INTERLOCK_EN
      resume_state <= resume_state_n;
      door_hold    <= door_hold_n;
`endif
    end
  end

  always_comb begin
    state_n      = state;
    presc_n      = presc;
    done_cnt_n   = done_cnt;
    time_n       = current_time;
    oven_start_n = 1'b0;
`ifdef DOOR_INTERLOCK_EN
    resume_state_n = resume_state;
    door_hold_n    = door_hold;
`endif

    if (stop) begin
      state_n = S_IDLE;
      time_n  = '0;
      presc_n = '0;
`ifdef DOOR_INTERLOCK_EN
      door_hold_n = 1'b0;
`endif
    end else if (start_ok && state == S_IDLE) begin
      state_n      = S_PREHEAT;
      time_n       = set_time;
      presc_n      = '0;
      oven_start_n = 1'b1;
    end else begin
      case (state)
        S_PREHEAT: begin
`ifdef DOOR_INTERLOCK_EN
          if (door_open) begin
            state_n        = S_PAUSE;
            resume_state_n = S_PREHEAT;
            door_hold_n    = 1'b1;
          end else
`endif
          if (in_band) begin
            state_n = S_COOK;
            presc_n = '0;
          end
        end
        S_COOK: begin
`ifdef DOOR_INTERLOCK_EN
          if (door_open) begin
            state_n        = S_PAUSE;
            resume_state_n = S_COOK;
            door_hold_n    = 1'b1;
          end else
`endif
          if (pause) begin
            state_n = S_PAUSE;
`ifdef DOOR_INTERLOCK_EN
            resume_state_n = S_COOK;
            door_hold_n    = 1'b0;
`endif
          end else if (presc == PW'(TICK_DIV - 1)) begin
            presc_n = '0;
            if (current_time <= 4'd1) begin
              time_n     = '0;
              state_n    = S_DONE;
              done_cnt_n = '0;
            end else begin
              time_n = current_time - 4'd1;
            end
          end else begin
            presc_n = presc + PW'(1);
          end
        end
        S_PAUSE: begin
`ifdef DOOR_INTERLOCK_EN
          if (door_open) begin
            door_hold_n = 1'b1;
          end else if (!pause) begin
            state_n      = resume_state;
            oven_start_n = door_hold;
            door_hold_n  = 1'b0;
          end
`else
          if (!pause) state_n = S_COOK;
`endif
        end
        S_DONE: begin
          time_n = '0;
          if (done_cnt == DW'(DONE_CYCLES - 1)) begin
            state_n = S_IDLE;
          end else begin
            done_cnt_n = done_cnt + DW'(1);
          end
        end
        default: state_n = S_IDLE;
      endcase
    end

    // Registered outputs are decoded from the next state so they line up with it.
    oven_stop_n = (state_n == S_IDLE) || (state_n == S_DONE);
`ifdef DOOR_INTERLOCK_EN
    if (state_n == S_PAUSE && door_open) oven_stop_n = 1'b1;
`endif
    done_led_n = (state_n == S_DONE);
    case (state_n)
      S_PREHEAT: phase_n = 2'd1;
      S_COOK:    phase_n = 2'd2;
      S_PAUSE:   phase_n = 2'd3;
      default:   phase_n = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_oven_cycle_sequencer.sv
// Randomized bench for oven_cycle_sequencer against a behavioural model that tracks
// elapsed cook clocks rather than a prescaler/down-counter pair.
module tb_oven_cycle_sequencer;

  localparam int unsigned TD = 4;
  localparam int unsigned IV = 10;
  localparam int unsigned DC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, stop = 1'b0, pause = 1'b0, door_open = 1'b0;
  logic [7:0] current_temp = '0, set_temp = '0;
  logic [3:0] set_time = '0;
  logic [3:0] current_time;
  logic       oven_start, oven_stop, done_led;
  logic [1:0] phase;

  oven_cycle_sequencer #(
    .TICK_DIV   (TD),
    .INTERVAL   (IV),
    .DONE_CYCLES(DC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .door_open   (door_open),
    .current_temp(current_temp),
    .set_temp    (set_temp),
    .set_time    (set_time),
    .current_time(current_time),
    .oven_start  (oven_start),
    .oven_stop   (oven_stop),
    .phase       (phase),
    .done_led    (done_led)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: mode 0 idle, 1 preheat, 2 cook, 3 pause, 4 done
  int m_mode, m_resume, m_loaded, m_cook_clks, m_done_left;
  bit m_pulse, m_prev_start, m_door_hold, m_door;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_resume = 2; m_loaded = 0; m_cook_clks = 0; m_done_left = 0;
    m_pulse = 0; m_prev_start = 0; m_door_hold = 0; m_door = 0;
  endtask

  task automatic model_step();
    bit edge_seen;
    bit door_en;
`ifdef DOOR_INTERLOCK_EN
    door_en = 1'b1;
`else
    door_en = 1'b0;
`endif
    edge_seen = start && !m_prev_start;
    m_prev_start = start;
    m_pulse = 0;
    m_door = door_open;
    if (stop) begin
      m_mode = 0; m_loaded = 0; m_cook_clks = 0; m_door_hold = 0;
    end else if (edge_seen && m_mode == 0 && set_time != 0 && !(door_en && door_open)) begin
      m_mode = 1; m_loaded = set_time; m_cook_clks = 0; m_pulse = 1;
    end else begin
      case (m_mode)
        1: begin
          if (door_en && door_open) begin
            m_mode = 3; m_resume = 1; m_door_hold = 1;
          end else if (int'(current_temp) + int'(IV) >= int'(set_temp)) begin
            m_mode = 2;
          end
        end
        2: begin
          if (door_en && door_open) begin
            m_mode = 3; m_resume = 2; m_door_hold = 1;
          end else if (pause) begin
            m_mode = 3; m_resume = 2; m_door_hold = 0;
          end else begin
            m_cook_clks++;
            if (m_cook_clks == m_loaded * int'(TD)) begin
              m_mode = 4; m_done_left = DC;
            end
          end
        end
        3: begin
          if (door_en && door_open) begin
            m_door_hold = 1;
          end else if (!pause) begin
            m_mode = m_resume; m_pulse = m_door_hold; m_door_hold = 0;
          end
        end
        4: begin
          m_done_left--;
          if (m_done_left == 0) m_mode = 0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_outputs(input string tag);
    int exp_time, exp_phase, exp_stop;
    exp_time  = (m_mode == 0 || m_mode == 4) ? 0 : m_loaded - m_cook_clks / int'(TD);
    exp_phase = (m_mode == 4) ? 0 : m_mode;
    exp_stop  = (m_mode == 0 || m_mode == 4) ? 1 : 0;
`ifdef DOOR_INTERLOCK_EN
    if (m_mode == 3 && m_door) exp_stop = 1;
`endif
    check({tag, ".time"},  int'(current_time), exp_time);
    check({tag, ".phase"}, int'(phase), exp_phase);
    check({tag, ".start"}, int'(oven_start), int'(m_pulse));
    check({tag, ".stop"},  int'(oven_stop), exp_stop);
    check({tag, ".led"},   int'(done_led), (m_mode == 4) ? 1 : 0);
  endtask

  task automatic cycle(input bit s, input bit sp, input bit p, input bit d,
                       input logic [7:0] ct, input logic [7:0] st, input logic [3:0] tm,
                       input string tag);
    @(negedge clk);
    start = s; stop = sp; pause = p; door_open = d;
    current_temp = ct; set_temp = st; set_time = tm;
    @(posedge clk);
    model_step();
    #1 check_outputs(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1 model_reset();
    check_outputs(tag);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_outputs("reset");
    @(negedge clk) rst = 1'b0;

    // start and stop together, then a start with zero time
    cycle(1, 1, 0, 0, 8'd95, 8'd100, 4'd3, "start_stop");
    cycle(0, 0, 0, 0, 8'd95, 8'd100, 4'd3, "idle");
    cycle(1, 0, 0, 0, 8'd95, 8'd100, 4'd0, "zero_time");
    cycle(0, 0, 0, 0, 8'd95, 8'd100, 4'd0, "idle2");

    // basic cycle: in band at once, runs to done and back to idle
    cycle(1, 0, 0, 0, 8'd95, 8'd100, 4'd3, "basic_go");
    for (int i = 0; i < 24; i++) cycle(1, 0, 0, 0, 8'd95, 8'd100, 4'd7, "basic_run");
    cycle(0, 0, 0, 0, 8'd95, 8'd100, 4'd3, "basic_idle");

    // long preheat, ramp into band, pause for 10 clocks mid-count
    cycle(1, 0, 0, 0, 8'd50, 8'd100, 4'd5, "pre_go");
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 8'd50, 8'd100, 4'd5, "pre_hold");
    cycle(0, 0, 0, 0, 8'd90, 8'd100, 4'd5, "pre_ramp");
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 8'd90, 8'd100, 4'd5, "cook");
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, 0, 8'd90, 8'd100, 4'd5, "paused");
    for (int i = 0; i < 30; i++) cycle(0, 0, 0, 0, 8'd90, 8'd100, 4'd5, "resume");

    // async reset while cooking with 5 remaining
    cycle(1, 0, 0, 0, 8'd95, 8'd100, 4'd5, "rst_go");
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 8'd95, 8'd100, 4'd5, "rst_cook");
    check("pre_rst_time", int'(current_time), 5);
    async_reset("mid_rst");

    // saturated band: set_temp below INTERVAL skips preheat
    cycle(1, 0, 0, 0, 8'd0, 8'd5, 4'd2, "sat_go");
    for (int i = 0; i < 15; i++) cycle(0, 0, 0, 1, 8'd0, 8'd5, 4'd2, "sat_run");

    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            4'($urandom_range(0, 15)), "rand");
      if (i == 2000) async_reset("rand_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
